// File: rtl/wb_decoder_2_pkg.sv
// rtl/wb_decoder_2_pkg.sv - shared types and helpers for the 1-to-2 Wishbone decoder
//
// Purpose : termination bundle type and timeout-counter width helper.
// Ports   : none (package).

package wb_decoder_2_pkg;

    // One slave's termination signals, muxed as a unit by the decoder.
    typedef struct packed {
        logic ack;
        logic err;
        logic rty;
    } term_t;

    // Counter must hold 0..TIMEOUT; keep at least one bit so a disabled
    // timeout (TIMEOUT=0) still yields a legal vector.
    function automatic int tcnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/wb_decoder_2_addr_match.sv
// rtl/wb_decoder_2_addr_match.sv - combinational base/mask address match
//
// Purpose : asserts o_hit-equivalent output when (adr & MASK) == ADDR.
// Ports   : adr_i [ADDR_WIDTH] address in; hit_o [1] match result.

module wb_addr_match #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR       = '0,
    parameter logic [ADDR_WIDTH-1:0] MASK       = '0
) (
    input  logic [ADDR_WIDTH-1:0] adr_i,
    output logic                  hit_o
);

    assign hit_o = ((adr_i & MASK) == ADDR);

endmodule

// File: rtl/wb_decoder_2.sv
// rtl/wb_decoder_2.sv - Wishbone 1-master to 2-slave address decoder with timeout
//
// Purpose : routes one master cycle to slave 0 or slave 1 by address/mask match,
//           terminates unmapped or stalled accesses with a one-cycle ERR.
// Ports   : clk, rst (sync, active-high)
//           wbm_*  : master side (adr/dat/we/sel/stb/cyc in; dat/ack/err/rty out)
//           wbs0_* : slave 0 side (adr/dat/we/sel/stb/cyc out; dat/ack/err/rty in)
//           wbs1_* : slave 1 side (same as slave 0)

module wb_decoder_2
    import wb_decoder_2_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    SELECT_WIDTH = DATA_WIDTH / 8,
    parameter logic [ADDR_WIDTH-1:0] SLV0_ADDR    = '0,
    parameter logic [ADDR_WIDTH-1:0] SLV0_MASK    = 32'hFFFF_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV1_ADDR    = 32'h0001_0000,
    parameter logic [ADDR_WIDTH-1:0] SLV1_MASK    = 32'hFFFF_0000,
    parameter int                    TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    input  logic                    wbm_cyc_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,

    output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
    output logic                    wbs0_we_o,
    output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
    output logic                    wbs0_stb_o,
    output logic                    wbs0_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
    input  logic                    wbs0_ack_i,
    input  logic                    wbs0_err_i,
    input  logic                    wbs0_rty_i,

    output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
    output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
    output logic                    wbs1_we_o,
    output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
    output logic                    wbs1_stb_o,
    output logic                    wbs1_cyc_o,
    input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
    input  logic                    wbs1_ack_i,
    input  logic                    wbs1_err_i,
    input  logic                    wbs1_rty_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int TW = tcnt_width(TIMEOUT);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic          r_sel_q;
    logic [TW-1:0] r_tcnt;

    logic          w_hit0;
    logic          w_hit1;
    logic          w_hit;
    logic          w_dec_sel;
    logic          w_req;
    term_t         w_sel_term;
    logic          w_term;
    logic          w_tmo;
    logic          w_enter_xfer;

    wb_addr_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR       (SLV0_ADDR),
        .MASK       (SLV0_MASK)
    ) u_match0 (
        .adr_i (wbm_adr_i),
        .hit_o (w_hit0)
    );

    wb_addr_match #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .ADDR       (SLV1_ADDR),
        .MASK       (SLV1_MASK)
    ) u_match1 (
        .adr_i (wbm_adr_i),
        .hit_o (w_hit1)
    );

    // Slave 0 wins overlapping windows; w_dec_sel is only used on a hit.
    assign w_hit     = w_hit0 | w_hit1;
    assign w_dec_sel = ~w_hit0;
    assign w_req     = wbm_cyc_i & wbm_stb_i;

    always_comb begin
        w_sel_term = '0;
        if (r_sel_q) begin
            w_sel_term = '{ack: wbs1_ack_i, err: wbs1_err_i, rty: wbs1_rty_i};
        end else begin
            w_sel_term = '{ack: wbs0_ack_i, err: wbs0_err_i, rty: wbs0_rty_i};
        end
    end

    // A termination only counts while the master is strobing; it is only
    // acted on in XFER.
    assign w_term = wbm_stb_i & (w_sel_term.ack | w_sel_term.err | w_sel_term.rty);
    assign w_tmo  = (TIMEOUT != 0) && (r_tcnt == TW'(TIMEOUT - 1));

    assign w_enter_xfer = ((r_state == S_IDLE) || (r_state == S_HOLD)) &&
                          (w_state_next == S_XFER);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next = w_hit ? S_XFER : S_ERR;
                end
            end
            S_XFER: begin
                if (!wbm_cyc_i) begin
                    w_state_next = S_IDLE;
                end else if (w_term) begin
                    w_state_next = S_HOLD;
                end else if (w_tmo) begin
                    w_state_next = S_ERR;
                end
            end
            S_HOLD: begin
                if (!wbm_cyc_i) begin
                    w_state_next = S_IDLE;
                end else if (wbm_stb_i) begin
                    w_state_next = w_hit ? S_XFER : S_ERR;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Selected slave index, latched each time an access is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q <= 1'b0;
        end else if (w_enter_xfer) begin
            r_sel_q <= w_dec_sel;
        end
    end

    // Stall counter: counts strobed XFER cycles without a termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (w_enter_xfer) begin
            r_tcnt <= '0;
        end else if (r_state == S_XFER) begin
            if (w_term) begin
                r_tcnt <= '0;
            end else if (wbm_stb_i) begin
                r_tcnt <= r_tcnt + 1'b1;
            end
        end
    end

    // Output logic: all gating derives from the registered state so reset
    // silences the buses on the same edge.
    always_comb begin
        wbs0_cyc_o = 1'b0;
        wbs0_stb_o = 1'b0;
        wbs1_cyc_o = 1'b0;
        wbs1_stb_o = 1'b0;
        wbm_ack_o  = 1'b0;
        wbm_err_o  = 1'b0;
        wbm_rty_o  = 1'b0;
        case (r_state)
            S_XFER: begin
                wbs0_cyc_o = ~r_sel_q;
                wbs0_stb_o = ~r_sel_q & wbm_stb_i;
                wbs1_cyc_o = r_sel_q;
                wbs1_stb_o = r_sel_q & wbm_stb_i;
                wbm_ack_o  = wbm_stb_i & w_sel_term.ack;
                wbm_err_o  = wbm_stb_i & w_sel_term.err;
                wbm_rty_o  = wbm_stb_i & w_sel_term.rty;
            end
            S_HOLD: begin
                // Keep the bus locked to the last slave between accesses.
                wbs0_cyc_o = ~r_sel_q;
                wbs1_cyc_o = r_sel_q;
            end
            S_ERR: begin
                wbm_err_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign wbm_dat_o  = r_sel_q ? wbs1_dat_i : wbs0_dat_i;

    assign wbs0_adr_o = wbm_adr_i;
    assign wbs0_dat_o = wbm_dat_i;
    assign wbs0_we_o  = wbm_we_i;
    assign wbs0_sel_o = wbm_sel_i;
    assign wbs1_adr_o = wbm_adr_i;
    assign wbs1_dat_o = wbm_dat_i;
    assign wbs1_we_o  = wbm_we_i;
    assign wbs1_sel_o = wbm_sel_i;

endmodule

// File: tb/tb_wb_decoder_2.sv
// tb/tb_wb_decoder_2.sv - self-checking bench for wb_decoder_2

module tb_wb_decoder_2;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
    logic        wbm_we_i, wbm_stb_i, wbm_cyc_i;
    logic [3:0]  wbm_sel_i;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [31:0] wbs0_adr_o, wbs0_dat_o, wbs0_dat_i;
    logic        wbs0_we_o, wbs0_stb_o, wbs0_cyc_o;
    logic [3:0]  wbs0_sel_o;
    logic        wbs0_ack_i, wbs0_err_i, wbs0_rty_i;
    logic [31:0] wbs1_adr_o, wbs1_dat_o, wbs1_dat_i;
    logic        wbs1_we_o, wbs1_stb_o, wbs1_cyc_o;
    logic [3:0]  wbs1_sel_o;
    logic        wbs1_ack_i, wbs1_err_i, wbs1_rty_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_decoder_2 #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_rty_o(wbm_rty_o),
        .wbs0_adr_o(wbs0_adr_o), .wbs0_dat_o(wbs0_dat_o), .wbs0_we_o(wbs0_we_o),
        .wbs0_sel_o(wbs0_sel_o), .wbs0_stb_o(wbs0_stb_o), .wbs0_cyc_o(wbs0_cyc_o),
        .wbs0_dat_i(wbs0_dat_i), .wbs0_ack_i(wbs0_ack_i), .wbs0_err_i(wbs0_err_i),
        .wbs0_rty_i(wbs0_rty_i),
        .wbs1_adr_o(wbs1_adr_o), .wbs1_dat_o(wbs1_dat_o), .wbs1_we_o(wbs1_we_o),
        .wbs1_sel_o(wbs1_sel_o), .wbs1_stb_o(wbs1_stb_o), .wbs1_cyc_o(wbs1_cyc_o),
        .wbs1_dat_i(wbs1_dat_i), .wbs1_ack_i(wbs1_ack_i), .wbs1_err_i(wbs1_err_i),
        .wbs1_rty_i(wbs1_rty_i)
    );

    // term: 0=ack 1=err 2=rty; slv: 0/1 target, 2 = unmapped
    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        int          term;
        logic [31:0] rdat;
        int          slv;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        wbm_cyc_i = 0; wbm_stb_i = 0; wbm_we_i = 0; wbm_sel_i = 4'h0;
        wbm_adr_i = 32'h0; wbm_dat_i = 32'h0;
        wbs0_ack_i = 0; wbs0_err_i = 0; wbs0_rty_i = 0;
        wbs1_ack_i = 0; wbs1_err_i = 0; wbs1_rty_i = 0;
    endtask

    task automatic run_vec(input vec_t v);
        logic sc, ss, oc;
        logic [31:0] sa;
        logic [3:0]  sl;
        logic        sw;
        wbm_adr_i = v.adr; wbm_we_i = v.we; wbm_sel_i = v.sel;
        wbm_dat_i = 32'hA5A5_0000 ^ v.adr;
        wbm_cyc_i = 1; wbm_stb_i = 1;
        #1;
        chk("lat_s0_stb", wbs0_stb_o, 0);
        chk("lat_s1_stb", wbs1_stb_o, 0);
        tick();
        if (v.slv == 2) begin
            #1;
            chk("miss_err", wbm_err_o, 1);
            chk("miss_s0cyc", wbs0_cyc_o, 0);
            chk("miss_s1cyc", wbs1_cyc_o, 0);
            chk("miss_ack", wbm_ack_o, 0);
            tick();
            idle_bus();
            #1;
            chk("miss_err_1cyc", wbm_err_o, 0);
        end else begin
            if (v.slv == 1) begin
                wbs1_dat_i = v.rdat; wbs0_dat_i = ~v.rdat;
                wbs1_ack_i = (v.term == 0); wbs1_err_i = (v.term == 1); wbs1_rty_i = (v.term == 2);
            end else begin
                wbs0_dat_i = v.rdat; wbs1_dat_i = ~v.rdat;
                wbs0_ack_i = (v.term == 0); wbs0_err_i = (v.term == 1); wbs0_rty_i = (v.term == 2);
            end
            #1;
            sc = v.slv ? wbs1_cyc_o : wbs0_cyc_o;
            ss = v.slv ? wbs1_stb_o : wbs0_stb_o;
            oc = v.slv ? wbs0_cyc_o : wbs1_cyc_o;
            sa = v.slv ? wbs1_adr_o : wbs0_adr_o;
            sw = v.slv ? wbs1_we_o  : wbs0_we_o;
            sl = v.slv ? wbs1_sel_o : wbs0_sel_o;
            chk("sel_cyc", sc, 1);
            chk("sel_stb", ss, 1);
            chk("other_cyc", oc, 0);
            chk("sel_adr", sa, v.adr);
            chk("sel_we", sw, v.we);
            chk("sel_sel", sl, v.sel);
            chk("m_ack", wbm_ack_o, v.term == 0);
            chk("m_err", wbm_err_o, v.term == 1);
            chk("m_rty", wbm_rty_o, v.term == 2);
            if (!v.we) chk("m_dat", wbm_dat_o, v.rdat);
            tick();
            idle_bus();
            #1;
            sc = v.slv ? wbs1_cyc_o : wbs0_cyc_o;
            chk("hold_cyc", sc, 1);
            chk("hold_ack", wbm_ack_o, 0);
        end
        tick();
        #1;
        chk("end_s0cyc", wbs0_cyc_o, 0);
        chk("end_s1cyc", wbs1_cyc_o, 0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0010, 1'b0, 4'hF, 0, 32'hDEAD_BEEF, 0};
        vecs[1] = '{32'h0001_0004, 1'b1, 4'h3, 0, 32'h0,         1};
        vecs[2] = '{32'h0002_0000, 1'b0, 4'hF, 0, 32'h0,         2};
        vecs[3] = '{32'h0000_FFFC, 1'b0, 4'hF, 0, 32'h0BAD_F00D, 0};
        vecs[4] = '{32'h0001_FFFF, 1'b0, 4'h1, 0, 32'h1234_5678, 1};
        vecs[5] = '{32'hFFFF_0000, 1'b1, 4'hF, 0, 32'h0,         2};
        vecs[6] = '{32'h0000_0100, 1'b0, 4'hF, 1, 32'h5555_AAAA, 0};
        vecs[7] = '{32'h0001_0200, 1'b1, 4'hC, 2, 32'h0,         1};

        idle_bus();
        wbs0_dat_i = 0; wbs1_dat_i = 0;
        rst = 1;
        tick(); tick();
        chk("rst_s0cyc", wbs0_cyc_o, 0);
        chk("rst_s1cyc", wbs1_cyc_o, 0);
        chk("rst_ack", wbm_ack_o, 0);
        chk("rst_err", wbm_err_o, 0);
        rst = 0;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Slave 0 acks on the third XFER cycle; slave 1 never engaged.
        wbm_adr_i = 32'h10; wbm_we_i = 0; wbm_sel_i = 4'hF; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick(); #1;
        chk("t1_s0stb", wbs0_stb_o, 1);
        chk("t1_noack", wbm_ack_o, 0);
        tick(); #1;
        chk("t1_noack2", wbm_ack_o, 0);
        chk("t1_s1cyc", wbs1_cyc_o, 0);
        tick();
        wbs0_ack_i = 1; wbs0_dat_i = 32'hDEAD_BEEF; #1;
        chk("t1_ack", wbm_ack_o, 1);
        chk("t1_dat", wbm_dat_o, 32'hDEAD_BEEF);
        tick(); idle_bus(); tick(); #1;

        // Stall until timeout.
        wbm_adr_i = 32'h20; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            #1;
            chk("tmo_wait_err", wbm_err_o, 0);
            chk("tmo_wait_cyc", wbs0_cyc_o, 1);
            tick();
        end
        #1;
        chk("tmo_err", wbm_err_o, 1);
        chk("tmo_cyc_drop", wbs0_cyc_o, 0);
        tick(); #1;
        chk("tmo_err_1cyc", wbm_err_o, 0);
        idle_bus(); tick();

        // Ack on the last stalled cycle beats the timeout.
        wbm_adr_i = 32'h24; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick();
        for (int k = 1; k <= TMO; k++) begin
            if (k == TMO) wbs0_ack_i = 1;
            #1;
            chk("tmo2_err", wbm_err_o, 0);
            if (k == TMO) chk("tmo2_ack", wbm_ack_o, 1);
            tick();
        end
        wbs0_ack_i = 0; wbm_stb_i = 0; #1;
        chk("tmo2_no_err", wbm_err_o, 0);
        chk("tmo2_hold_cyc", wbs0_cyc_o, 1);
        idle_bus(); tick(); tick();

        // Block cycle: slave 0 then slave 1 with cyc held high.
        wbm_adr_i = 32'h40; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick();
        wbs0_ack_i = 1; #1;
        chk("blk_ack0", wbm_ack_o, 1);
        tick();
        wbs0_ack_i = 0; wbm_stb_i = 0; #1;
        chk("blk_hold_s0cyc", wbs0_cyc_o, 1);
        chk("blk_hold_s0stb", wbs0_stb_o, 0);
        tick();
        wbm_adr_i = 32'h0001_0040; wbm_stb_i = 1; #1;
        chk("blk_hold2_s0cyc", wbs0_cyc_o, 1);
        chk("blk_hold2_s1cyc", wbs1_cyc_o, 0);
        tick();
        wbs1_ack_i = 1; wbs1_dat_i = 32'hCAFE_0001; #1;
        chk("blk_s0cyc_drop", wbs0_cyc_o, 0);
        chk("blk_s1cyc", wbs1_cyc_o, 1);
        chk("blk_s1stb", wbs1_stb_o, 1);
        chk("blk_ack1", wbm_ack_o, 1);
        chk("blk_dat1", wbm_dat_o, 32'hCAFE_0001);
        tick(); idle_bus(); tick(); #1;
        chk("blk_end", wbs1_cyc_o, 0);

        // Reset in the middle of an XFER.
        wbm_adr_i = 32'h0001_0008; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick(); #1;
        chk("rx_s1cyc", wbs1_cyc_o, 1);
        rst = 1; wbs1_ack_i = 1;
        tick(); #1;
        chk("rx_s1cyc0", wbs1_cyc_o, 0);
        chk("rx_s1stb0", wbs1_stb_o, 0);
        chk("rx_ack0", wbm_ack_o, 0);
        chk("rx_err0", wbm_err_o, 0);
        rst = 0; idle_bus();
        tick();
        wbm_adr_i = 32'h8; wbm_cyc_i = 1; wbm_stb_i = 1;
        tick(); #1;
        chk("rx_after_s0stb", wbs0_stb_o, 1);
        chk("rx_after_s1cyc", wbs1_cyc_o, 0);
        idle_bus(); tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
